dmi_arbiter: RTL
================

# dmi_arbiter

Shares the single debug-module DMI request/response port between two masters: requester 0 (JTAG DTM) and requester 1 (SoC-side debug mailbox). It arbitrates round-robin and keeps exactly one DMI transaction outstanding. It routes each response back to the requester that issued the request. It sits between the DTM/mailbox and the debug module front end, and uses `dm::dmi_req_t` (41 b: addr[6:0], op[1:0], data[31:0]) and `dm::dmi_resp_t` (34 b: data[31:0], resp[1:0]).

## Interface
Parameters:
- `TimeoutCycles`, default 1024: WAIT-state cycles before a synthesized failure response; only used with the timeout feature.

Ports (clock and reset first):
- `clk_i`  in  1  sole clock; all logic is rising-edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_valid_i`  in  2  per-requester request valid.
- `req_ready_o`  out  2  per-requester request accept.
- `req_i`  in  2×41  per-requester `dm::dmi_req_t`.
- `resp_valid_o`  out  2  per-requester response valid.
- `resp_ready_i`  in  2  per-requester response accept.
- `resp_o`  out  34  `dm::dmi_resp_t`; shared by both requesters, meaningful only with the matching `resp_valid_o` bit.
- `dmi_req_valid_o` / `dmi_req_ready_i`  out / in  1 / 1  downstream request handshake.
- `dmi_req_o`  out  41  registered downstream request.
- `dmi_resp_valid_i` / `dmi_resp_ready_o`  in / out  1 / 1  downstream response handshake.
- `dmi_resp_i`  in  34  downstream response.
- `busy_o`  out  1  state != IDLE.
- `owner_o`  out  1  index of the current or last granted requester.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any `req_valid_i` is set and the drain flag is clear: grant the winner and assert its `req_ready_o` combinationally.
  - On that handshake: capture `req_i[g]` into the request register, set owner = g, go to REQ.
- Arbitration is round-robin. Priority pointer = requester not served last; reset pointer favours requester 0. If only one requester is valid it wins regardless of the pointer.
- REQ: `dmi_req_valid_o`=1. On `dmi_req_ready_i` go to WAIT.
- WAIT: `dmi_resp_ready_o`=1. On `dmi_resp_valid_i` capture `dmi_resp_i` and go to RESP.
- RESP: `resp_valid_o[owner]`=1. On `resp_ready_i[owner]`, move the pointer to the other requester and go to IDLE.
- All ops, including `DTM_NOP`, are forwarded unchanged. The arbiter never inspects addr or data.
- Stable-hold rules:
  - `dmi_req_o` holds stable while `dmi_req_valid_o` is set.
  - `resp_o` holds stable while `resp_valid_o` is set.
- The non-owner's `req_ready_o` and `resp_valid_o` are always 0 outside IDLE.
- A downstream response arriving outside WAIT with the drain flag clear is a protocol violation. It is not accepted: `dmi_resp_ready_o`=0.

## Timing
- Reset values: FSM=IDLE, pointer→requester 0, `owner_o`=0, `busy_o`=0, all valid/ready outputs 0, `dmi_req_o`=0, `resp_o`=0, drain flag=0, timeout counter=0.
- A reset asserted mid-transaction returns to IDLE on the next edge. Any in-flight downstream response is not tracked afterwards.
- Latency from upstream accept to downstream response capture, with zero-wait downstream:
  - Accept in cycle 0.
  - `dmi_req_valid_o` in cycle 1.
  - WAIT in cycle 2.
  - RESP one cycle after `dmi_resp_valid_i`.
  - Minimum upstream round trip: 4 cycles.
- A new grant is possible the cycle after the RESP handshake. Back-to-back throughput is one transaction per 4 cycles minimum.
- Simultaneous `req_valid_i`=2'b11 in IDLE: the pointer decides. The loser's `req_valid_i` stays pending with no ready.

## Configuration
- Macro: `DMI_ARB_TIMEOUT_EN`.
- Defined:
  - A counter (width $clog2(TimeoutCycles+1)) counts WAIT cycles and clears on entering WAIT.
  - On reaching `TimeoutCycles` without a response, load `resp_o` = {data=0, resp=2'h2} (failed), set the drain flag, and go to RESP.
  - While the drain flag is set: `dmi_resp_ready_o`=1 and no new grants are made.
  - A late response is accepted and discarded, and the flag clears.
  - If no response arrives within a further `TimeoutCycles` cycles, the flag clears anyway.
- Undefined: no counter, no drain flag, and WAIT lasts until a response arrives.

## Test plan
- Single read: requester 0 sends {addr=7'h11, op=1, data=0}. Downstream returns {data=32'h0040_0C82, resp=0} in 2 cycles. Requester 0 receives that response exactly; requester 1 sees no valid; `owner_o`=0.
- Contention: both requesters are valid from reset in IDLE. Grant order is 0, 1, 0, 1 across 4 transactions. Each response goes to the issuer, and no request is duplicated or dropped.
- Backpressure: `dmi_req_ready_i` is held low for 10 cycles, then `resp_ready_i[owner]` low for 5 cycles. `dmi_req_o` and `resp_o` stay stable; there is no second grant meanwhile.
- Mid-transaction reset: `rst_i` is pulsed in WAIT. The next cycle shows IDLE, all valids 0, and `busy_o`=0. A following request from requester 1 completes normally.
- Timeout (macro defined, `TimeoutCycles`=16): the downstream never responds. Requester 0 gets {data=0, resp=2'h2} at WAIT cycle 16. A late response at cycle 20 is consumed and not forwarded. Requester 1's pending request is granted only after the drain.
- Timeout macro undefined: the downstream responds after 2000 cycles. That response is forwarded intact with no failure response.

Source files
------------

// File: rtl/dmi_arbiter.sv
// -----------------------------------------------------------------------------
// dmi_arbiter
//
// Shares the single debug-module DMI port between two masters:
//   requester 0 = JTAG DTM, requester 1 = SoC-side debug mailbox.
// Requests are granted round-robin. Exactly one DMI transaction is outstanding
// at any time, and each response is routed back to the requester that issued
// the request.
//
// Payload layouts (kept as flat vectors so this file stands alone; the bit
// order matches the packed dm::dmi_req_t / dm::dmi_resp_t structs):
//   request  [40:0] = {addr[6:0], op[1:0], data[31:0]}
//   response [33:0] = {data[31:0], resp[1:0]}
// The arbiter never looks inside either payload.
//
// Optional feature macro: DMI_ARB_TIMEOUT_EN
//   When defined, a WAIT-state watchdog synthesizes a failed response
//   (resp = 2'h2, data = 0) after TimeoutCycles cycles. It then drains the
//   late downstream response before it allows a new grant.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester request handshake (2 bits)
//   req_i                 per-requester request payload (2 x 41 b)
//   resp_valid_o/ready_i  per-requester response handshake (2 bits)
//   resp_o                shared response payload (34 b), qualified by valid
//   dmi_req_*             downstream request handshake + registered payload
//   dmi_resp_*            downstream response handshake + payload
//   busy_o                FSM not idle
//   owner_o               current / last granted requester
// -----------------------------------------------------------------------------
module dmi_arbiter #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][40:0] req_i,
  output logic [1:0]       resp_valid_o,
  input  logic [1:0]       resp_ready_i,
  output logic [33:0]      resp_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [40:0]      dmi_req_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [33:0]      dmi_resp_i,
  output logic             busy_o,
  output logic             owner_o
);

  localparam int unsigned NumReq = 2;

  // A zero timeout would make the watchdog fire before any response could
  // ever arrive, so it is rejected at elaboration.
  if (TimeoutCycles == 0) begin : g_bad_timeout
    $error("dmi_arbiter: TimeoutCycles must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;      // requester that wins a tie
  logic         owner_q, owner_d;
  logic [40:0]  req_q, req_d;
  logic [33:0]  resp_q, resp_d;

  logic         grant_valid;
  logic         grant_idx;
  logic         drain_act;         // a timed-out response is still expected
  logic         tmo_hit;           // watchdog expires this cycle

  // ---------------------------------------------------------------------------
  // Arbitration. A lone requester wins regardless of the pointer; on a tie the
  // pointer, which always names the requester not served last, decides.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_idx = ptr_q;
    if (req_valid_i == 2'b01) begin
      grant_idx = 1'b0;
    end else if (req_valid_i == 2'b10) begin
      grant_idx = 1'b1;
    end
  end

  assign grant_valid = (state_q == IDLE) && (|req_valid_i) && !drain_act;

  // Per-requester handshake outputs. The non-owner always sees 0 here.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
    assign req_ready_o[gi]  = grant_valid && (grant_idx == 1'(gi));
    assign resp_valid_o[gi] = (state_q == RESP) && (owner_q == 1'(gi));
  end

  // ---------------------------------------------------------------------------
  // Main FSM: next state and data capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    req_d           = req_q;
    resp_d          = resp_q;
    dmi_req_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        // req_ready_o is raised only for a valid requester, so a grant is
        // also the handshake.
        if (grant_valid) begin
          req_d   = req_i[grant_idx];
          owner_d = grant_idx;
          state_d = REQ;
        end
      end

      REQ: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A real response has priority over an expiring watchdog.
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_i;
          state_d = RESP;
        end else if (tmo_hit) begin
          resp_d  = {32'h0000_0000, 2'h2};
          state_d = RESP;
        end
      end

      RESP: begin
        if (resp_ready_i[owner_q]) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog. One counter serves two purposes. In WAIT it times the
  // outstanding response. After a timeout it times the drain window, during
  // which a late response is swallowed. The two uses never overlap, because
  // no grant is made while draining.
  // ---------------------------------------------------------------------------
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drain_q, drain_d;

  assign drain_act = drain_q;
  assign tmo_hit   = (state_q == WAIT) && (cnt_q == TmoLast);

  always_comb begin
    cnt_d   = cnt_q;
    drain_d = drain_q;
    if ((state_q == REQ) && dmi_req_ready_i) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (dmi_resp_valid_i) begin
        cnt_d = '0;
      end else if (tmo_hit) begin
        cnt_d   = '0;
        drain_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (drain_q) begin
      // Either the late response shows up and is dropped, or the window closes.
      if (dmi_resp_valid_i || (cnt_q == TmoLast)) begin
        cnt_d   = '0;
        drain_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end
`else
  assign drain_act = 1'b0;
  assign tmo_hit   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. Payloads come straight from registers, so they hold stable while
  // their valid is high.
  // ---------------------------------------------------------------------------
  assign dmi_req_o        = req_q;
  assign resp_o           = resp_q;
  assign dmi_resp_ready_o = (state_q == WAIT) || drain_act;
  assign busy_o           = (state_q != IDLE);
  assign owner_o          = owner_q;

endmodule
